// File: rtl/sc_backg_pkg.sv
// Shared definitions for the background speed timer: state encoding, level width, default limits.
package sc_backg_pkg;

  localparam int unsigned LEVEL_W              = 3;
  localparam int unsigned DEF_DATAWIDTH        = 24;
  localparam logic [23:0] DEF_BASE_LIMIT       = 24'd5000000;
  localparam logic [23:0] DEF_MIN_LIMIT        = 24'd500000;
  localparam int unsigned DEF_SHIFTS_PER_LEVEL = 16;
  localparam int unsigned DEF_LEVEL_MAX        = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_EXPIRED = 2'b10
  } state_e;

endpackage

// File: rtl/sc_backg_levelctr.sv
// Shift-progress counter feeding a saturating speed-level register.
module sc_backg_levelctr
  import sc_backg_pkg::*;
#(
  parameter int unsigned SHIFTS_PER_LEVEL = DEF_SHIFTS_PER_LEVEL,
  parameter int unsigned LEVEL_MAX        = DEF_LEVEL_MAX
) (
  input  logic               SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic               SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic               clear_i,
  input  logic               shift_i,
  output logic [LEVEL_W-1:0] level_o
);

  localparam int unsigned PROG_W = (SHIFTS_PER_LEVEL > 1) ? $clog2(SHIFTS_PER_LEVEL) : 1;
  localparam logic [PROG_W-1:0]  PROG_LAST = PROG_W'(SHIFTS_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LVL_TOP   = LEVEL_W'(LEVEL_MAX);

  logic [PROG_W-1:0]  prog_q, prog_d;
  logic [LEVEL_W-1:0] level_q, level_d;

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      prog_q  <= '0;
      level_q <= '0;
    end else begin
      prog_q  <= prog_d;
      level_q <= level_d;
    end
  end

  // Clear dominates; the last shift of a level wraps progress and steps the level.
  always_comb begin
    prog_d  = prog_q;
    level_d = level_q;
    if (clear_i) begin
      prog_d  = '0;
      level_d = '0;
    end else if (shift_i) begin
      if (prog_q >= PROG_LAST) begin
        prog_d = '0;
        if (level_q < LVL_TOP) level_d = level_q + LEVEL_W'(1);
      end else begin
        prog_d = prog_q + PROG_W'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/sc_backg_speedtimer.sv
// Background drop timer with terminal-count flag; level speed-up enabled by SC_BACKG_SPEEDUP_EN.
module sc_backg_speedtimer
  import sc_backg_pkg::*;
#(
  parameter int unsigned              DATAWIDTH_BUS    = DEF_DATAWIDTH,
  parameter logic [DATAWIDTH_BUS-1:0] BASE_LIMIT       = DATAWIDTH_BUS'(DEF_BASE_LIMIT),
  parameter logic [DATAWIDTH_BUS-1:0] MIN_LIMIT        = DATAWIDTH_BUS'(DEF_MIN_LIMIT),
  parameter int unsigned              SHIFTS_PER_LEVEL = DEF_SHIFTS_PER_LEVEL,
  parameter int unsigned              LEVEL_MAX        = DEF_LEVEL_MAX
) (
  input  logic               SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic               SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic               upcount_InLow,
  input  logic               clear_InLow,
  input  logic               shift_InLow,
  output logic               T0_OutLow,
  output logic [LEVEL_W-1:0] level_Out
);

  localparam int unsigned CW = DATAWIDTH_BUS + 1;

  if (LEVEL_MAX >= (1 << LEVEL_W) || SHIFTS_PER_LEVEL == 0 || MIN_LIMIT > BASE_LIMIT) begin : g_cfg_err
    $error("sc_backg_speedtimer: inconsistent parameter set");
  end

  state_e                   state_q, state_d;
  logic [DATAWIDTH_BUS-1:0] cnt_q, cnt_d;
  logic                     t0_q, t0_d;
  logic [CW-1:0]            cnt_inc_c;
  logic [DATAWIDTH_BUS-1:0] limit_c;
  logic [LEVEL_W-1:0]       level_c;
  logic                     clear_c, shift_c, up_c;

  assign clear_c = ~clear_InLow;
  assign shift_c = ~shift_InLow & clear_InLow;
  assign up_c    = ~upcount_InLow;

`ifdef SC_BACKG_SPEEDUP_EN
  logic [DATAWIDTH_BUS-1:0] shifted_c;

  sc_backg_levelctr #(
    .SHIFTS_PER_LEVEL (SHIFTS_PER_LEVEL),
    .LEVEL_MAX        (LEVEL_MAX)
  ) u_levelctr (
    .SC_STATEMACHINEBACKG_CLOCK_50     (SC_STATEMACHINEBACKG_CLOCK_50),
    .SC_STATEMACHINEBACKG_RESET_InHigh (SC_STATEMACHINEBACKG_RESET_InHigh),
    .clear_i                           (clear_c),
    .shift_i                           (shift_c),
    .level_o                           (level_c)
  );

  // Each level halves the limit, floored so high levels stay playable.
  assign shifted_c = BASE_LIMIT >> level_c;
  assign limit_c   = (shifted_c < MIN_LIMIT) ? MIN_LIMIT : shifted_c;
`else
  assign level_c = '0;
  assign limit_c = BASE_LIMIT;
`endif

  // One extra bit so the +1 compare can never wrap.
  assign cnt_inc_c = {1'b0, cnt_q} + CW'(1);

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      t0_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t0_q    <= t0_d;
    end
  end

  // Priority: clear, then shift, then upcount.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear_c || shift_c) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (up_c) begin
            state_d = ST_RUN;
            cnt_d   = DATAWIDTH_BUS'(1);
          end
        end
        ST_RUN: begin
          if (up_c) begin
            if (cnt_inc_c >= {1'b0, limit_c}) state_d = ST_EXPIRED;
            else                              cnt_d   = cnt_inc_c[DATAWIDTH_BUS-1:0];
          end
        end
        ST_EXPIRED: ;
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    t0_d = (state_d != ST_EXPIRED);
  end

  assign T0_OutLow = t0_q;
  assign level_Out = level_c;

endmodule

// File: tb/tb_sc_backg_speedtimer.sv
// Directed self-checking bench for sc_backg_speedtimer (both SC_BACKG_SPEEDUP_EN builds).
module tb_sc_backg_speedtimer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       up_n = 1'b1;
  logic       clr_n = 1'b1;
  logic       sh_n = 1'b1;
  logic       t0_n;
  logic [2:0] level;

  int passed = 0;
  int total  = 0;

  sc_backg_speedtimer #(
    .DATAWIDTH_BUS    (24),
    .BASE_LIMIT       (24'd8),
    .MIN_LIMIT        (24'd2),
    .SHIFTS_PER_LEVEL (2),
    .LEVEL_MAX        (3)
  ) dut (
    .SC_STATEMACHINEBACKG_CLOCK_50     (clk),
    .SC_STATEMACHINEBACKG_RESET_InHigh (rst),
    .upcount_InLow                     (up_n),
    .clear_InLow                       (clr_n),
    .shift_InLow                       (sh_n),
    .T0_OutLow                         (t0_n),
    .level_Out                         (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Apply one cycle of inputs and land 1 time unit after the sampling edge.
  task automatic cyc(input logic u, input logic c, input logic s);
    up_n  = u;
    clr_n = c;
    sh_n  = s;
    @(posedge clk);
    #1;
  endtask

  // n upcount strobes from IDLE: flag high after n-1, low after n.
  task automatic run_to_expiry(input int n, input string tag);
    for (int i = 1; i < n; i++) cyc(1'b0, 1'b1, 1'b1);
    chk({tag, "_pre"}, 32'(t0_n), 32'd1);
    cyc(1'b0, 1'b1, 1'b1);
    chk({tag, "_exp"}, 32'(t0_n), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_t0", 32'(t0_n), 32'd1);
    chk("reset_level", 32'(level), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b1);
    chk("idle_t0", 32'(t0_n), 32'd1);

    // Base limit 8 at level 0, then the flag holds through idle and upcount.
    run_to_expiry(8, "base");
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("expired_hold", 32'(t0_n), 32'd0);

`ifdef SC_BACKG_SPEEDUP_EN
    cyc(1'b1, 1'b1, 1'b0);
    chk("shift1_t0", 32'(t0_n), 32'd1);
    chk("shift1_level", 32'(level), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("shift2_level", 32'(level), 32'd1);
    run_to_expiry(4, "lvl1");

    repeat (4) cyc(1'b1, 1'b1, 1'b0);
    chk("shift6_level", 32'(level), 32'd3);
    run_to_expiry(2, "lvl3_floor");
    repeat (2) cyc(1'b1, 1'b1, 1'b0);
    chk("saturate_level", 32'(level), 32'd3);

    // Shift and upcount together in RUN: shift wins, counter restarts.
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("shift_up_t0", 32'(t0_n), 32'd1);
    run_to_expiry(2, "after_shift_up");

    cyc(1'b1, 1'b0, 1'b1);
    chk("clear_level", 32'(level), 32'd0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0);
    chk("lvl2_level", 32'(level), 32'd2);
    run_to_expiry(2, "lvl2");
    cyc(1'b1, 1'b0, 1'b0);
    chk("clear_exp_t0", 32'(t0_n), 32'd1);
    chk("clear_exp_level", 32'(level), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("post_clear_shift1", 32'(level), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("post_clear_shift2", 32'(level), 32'd1);
    run_to_expiry(4, "post_clear_lvl1");

    // Asynchronous reset clears level and flag without a clock edge.
    rst = 1'b1;
    #2;
    chk("rst_async_level", 32'(level), 32'd0);
    chk("rst_async_t0_lvl", 32'(t0_n), 32'd1);
    #1 rst = 1'b0;
`else
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (i % 2 == 1) begin
        chk("nomacro_level", 32'(level), 32'd0);
        run_to_expiry(8, "nomacro");
      end
    end
    cyc(1'b1, 1'b0, 1'b1);
`endif

    // Reset mid-RUN at count 5: full 8 upcounts needed afterwards.
    repeat (5) cyc(1'b0, 1'b1, 1'b1);
    chk("run5_t0", 32'(t0_n), 32'd1);
    up_n = 1'b1;
    rst  = 1'b1;
    #2;
    chk("rst_run_t0", 32'(t0_n), 32'd1);
    #1 rst = 1'b0;
    run_to_expiry(8, "restart");

    // Reset while expired drops the flag at once and nothing stale follows.
    up_n = 1'b1;
    rst  = 1'b1;
    #2;
    chk("rst_exp_t0", 32'(t0_n), 32'd1);
    chk("rst_exp_level", 32'(level), 32'd0);
    #1 rst = 1'b0;
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    chk("no_stale_t0", 32'(t0_n), 32'd1);
    run_to_expiry(8, "final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
